// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared types for the memory-port arbiter: access size encoding
//            (same encoding the control unit drives on wb_store_size), FSM
//            state and owner enums, and an alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Access size, shared with the control unit.
  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_LO = 2'd1,
    BEAT_HI = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } arb_owner_e;

  // Plain-vector state constants for the legacy-style state register.
  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_BEAT_LO = 2'(BEAT_LO);
  localparam logic [1:0] ST_BEAT_HI = 2'(BEAT_HI);
  localparam logic [1:0] ST_RESP    = 2'(RESP);

  // Word needs 4-byte alignment, half-word needs 2-byte; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if (size == SIZE_W)      r = (addr_lo != 2'b00);
    else if (size == SIZE_H) r = addr_lo[0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_steer.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_steer
// Purpose  : Combinational lane steering for one 16-bit beat: byte enables,
//            outgoing write half-word and placement of the read byte/half.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_steer
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_beat_hi,
  input  logic [31:0] i_wdata,
  input  logic [15:0] i_rdata,
  output logic [1:0]  o_be,
  output logic [15:0] o_wdata,
  output logic [15:0] o_rdata
);

  // Bit 1 of the address does not affect lane selection within a half-word.
  logic w_unused_addr1;
  assign w_unused_addr1 = i_addr_lo[1];

  // Select enables, write lanes and read-byte shift from size and address.
  always_comb begin
    o_be    = 2'b11;
    o_wdata = i_wdata[15:0];
    o_rdata = i_rdata;
    case (i_size)
      SIZE_W: begin
        if (i_beat_hi) o_wdata = i_wdata[31:16];
      end
      SIZE_B: begin
        o_be    = i_addr_lo[0] ? 2'b10 : 2'b01;
        o_wdata = {2{i_wdata[7:0]}};
        o_rdata = {8'h00, (i_addr_lo[0] ? i_rdata[15:8] : i_rdata[7:0])};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one 16-bit memory port between instruction fetch and the
//            LSU. Word accesses take two beats (low half first), byte and
//            half-word accesses take one. Misaligned LSU requests are
//            rejected in IDLE without touching memory.
// Options  : MEM_ARB_RR_EN - round-robin on ties (default: LSU priority).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              first_cycle,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [1:0]        ls_size_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [31:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_done_o,
  output logic [31:0]       ls_rdata_o,
  output logic              ls_misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_be_o,
  output logic [HALF_W-1:0] mem_wdata_o,
  input  logic [HALF_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  logic [1:0]        r_state;
  arb_owner_e        r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [HALF_W-1:0] r_lo;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_ls_rdata;

  logic              w_idle;
  logic              w_ls_prio;
  logic              w_pick_ls;
  logic              w_ls_mis;
  logic              w_start;
  logic              w_beat_hi;
  logic              w_beat_done;
  logic              w_last_beat;
  logic [1:0]        w_be;
  logic [HALF_W-1:0] w_wdata;
  logic [HALF_W-1:0] w_rplace;
  logic [31:0]       w_rd_final;

  // Grants are only legal in IDLE and never while reset is held.
  assign w_idle = (r_state == ST_IDLE) && first_cycle;

`ifdef MEM_ARB_RR_EN
  arb_owner_e r_last;
  // On a tie the LSU wins only if fetch owned the port last.
  assign w_ls_prio = (r_last == OWNER_IF);

  // Remember the owner of each transaction that actually reaches memory.
  always_ff @(posedge clk or negedge first_cycle) begin
    if (!first_cycle)  r_last <= OWNER_IF;
    else if (w_start)  r_last <= w_pick_ls ? OWNER_LS : OWNER_IF;
  end
`else
  assign w_ls_prio = 1'b1;
`endif

  assign w_pick_ls     = ls_req_i && (!if_req_i || w_ls_prio);
  assign w_ls_mis      = is_misaligned(ls_size_i, ls_addr_i[1:0]);
  assign ls_gnt_o      = w_idle && w_pick_ls;
  assign if_gnt_o      = w_idle && if_req_i && !w_pick_ls;
  assign ls_misalign_o = ls_gnt_o && w_ls_mis;
  assign w_start       = if_gnt_o || (ls_gnt_o && !w_ls_mis);

  assign w_beat_hi   = (r_state == ST_BEAT_HI);
  assign mem_req_o   = ((r_state == ST_BEAT_LO) || w_beat_hi) && first_cycle;
  assign w_beat_done = mem_req_o && mem_ready_i;
  assign w_last_beat = w_beat_done && (w_beat_hi || (r_size != SIZE_W));

  mem_lane_steer u_steer (
    .i_size    (r_size),
    .i_addr_lo (r_addr[1:0]),
    .i_beat_hi (w_beat_hi),
    .i_wdata   (r_wdata),
    .i_rdata   (mem_rdata_i),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rplace)
  );

  // Words pair the captured low half with the live high half.
  assign w_rd_final = (r_size == SIZE_W) ? {mem_rdata_i, r_lo}
                                         : {16'h0000, w_rplace};

  // Beat address: words step through both halves, others hit one half-word.
  always_comb begin
    mem_addr_o = '0;
    if (mem_req_o) begin
      if (r_size == SIZE_W) mem_addr_o = {r_addr[ADDR_W-1:2], w_beat_hi, 1'b0};
      else                  mem_addr_o = {r_addr[ADDR_W-1:1], 1'b0};
    end
  end

  assign mem_we_o    = mem_req_o && r_we;
  assign mem_be_o    = mem_req_o ? w_be : 2'b00;
  assign mem_wdata_o = mem_req_o ? w_wdata : '0;

  assign if_rvalid_o = (r_state == ST_RESP) && (r_owner == OWNER_IF);
  assign ls_done_o   = (r_state == ST_RESP) && (r_owner == OWNER_LS);
  assign if_rdata_o  = r_if_rdata;
  assign ls_rdata_o  = r_ls_rdata;

  // Transaction FSM: latch on grant, run beats, pulse response for one cycle.
  always_ff @(posedge clk or negedge first_cycle) begin
    if (!first_cycle) begin
      r_state <= ST_IDLE;
      r_owner <= OWNER_IF;
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_BEAT_LO;
            r_owner <= w_pick_ls ? OWNER_LS : OWNER_IF;
            r_addr  <= w_pick_ls ? ls_addr_i : if_addr_i;
            r_size  <= w_pick_ls ? ls_size_i : 2'(SIZE_W);
            r_we    <= w_pick_ls && ls_we_i;
            r_wdata <= ls_wdata_i;
          end
        end
        ST_BEAT_LO: begin
          if (w_beat_done) begin
            r_lo    <= mem_rdata_i;
            r_state <= (r_size == SIZE_W) ? ST_BEAT_HI : ST_RESP;
          end
        end
        ST_BEAT_HI: begin
          if (w_beat_done) r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Update the owner's read data on the final beat so it is valid in RESP.
  always_ff @(posedge clk or negedge first_cycle) begin
    if (!first_cycle) begin
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else if (w_last_beat) begin
      if (r_owner == OWNER_IF) r_if_rdata <= w_rd_final;
      else if (!r_we)          r_ls_rdata <= w_rd_final;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        first_cycle;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i, ls_we_i;
  logic [1:0]  ls_size_i;
  logic [31:0] ls_addr_i, ls_wdata_i;
  logic        ls_gnt_o, ls_done_o, ls_misalign_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_be_o;
  logic [15:0] mem_wdata_o, mem_rdata_i;
  logic        mem_ready_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .first_cycle  (first_cycle),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .ls_req_i     (ls_req_i),
    .ls_we_i      (ls_we_i),
    .ls_size_i    (ls_size_i),
    .ls_addr_i    (ls_addr_i),
    .ls_wdata_i   (ls_wdata_i),
    .ls_gnt_o     (ls_gnt_o),
    .ls_done_o    (ls_done_o),
    .ls_rdata_o   (ls_rdata_o),
    .ls_misalign_o(ls_misalign_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ready_i  (mem_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    first_cycle = 1'b0;
    if_req_i = 0; if_addr_i = 0;
    ls_req_i = 0; ls_we_i = 0; ls_size_i = 2'b00; ls_addr_i = 0; ls_wdata_i = 0;
    mem_rdata_i = 0; mem_ready_i = 1;
    #2;
    check("rst_mem_req", {31'b0, mem_req_o}, 0);
    check("rst_outs", {if_gnt_o, if_rvalid_o, ls_gnt_o, ls_done_o, ls_misalign_o, mem_we_o, mem_be_o}, 0);
    check("rst_rdata", if_rdata_o | ls_rdata_o, 0);
    step(); step();
    first_cycle = 1'b1;
    #1;

    // Tie: LSU LH 0x10 vs IF 0x40 -> LSU first, IF right after RESP.
    ls_req_i = 1; ls_we_i = 0; ls_size_i = 2'b01; ls_addr_i = 32'h10;
    if_req_i = 1; if_addr_i = 32'h40;
    #1;
    check("tie_ls_gnt", {31'b0, ls_gnt_o}, 1);
    check("tie_if_gnt", {31'b0, if_gnt_o}, 0);
    step(); ls_req_i = 0; mem_rdata_i = 16'hBEEF; #1;
    check("lh_req", {31'b0, mem_req_o}, 1);
    check("lh_addr", mem_addr_o, 32'h10);
    check("lh_be", {30'b0, mem_be_o}, 2'b11);
    check("lh_if_wait", {31'b0, if_gnt_o}, 0);
    step();
    check("lh_done", {31'b0, ls_done_o}, 1);
    check("lh_rdata", ls_rdata_o, 32'h0000BEEF);
    check("lh_resp_noreq", {31'b0, mem_req_o}, 0);
    check("lh_resp_if_wait", {31'b0, if_gnt_o}, 0);
    step();
    check("if_gnt_after", {31'b0, if_gnt_o}, 1);
    check("if_gnt_ls0", {31'b0, ls_gnt_o}, 0);
    step(); if_req_i = 0; mem_rdata_i = 16'h1111; #1;
    check("if_lo_addr", mem_addr_o, 32'h40);
    step(); mem_rdata_i = 16'h2222; #1;
    check("if_hi_addr", mem_addr_o, 32'h42);
    step();
    check("if_rvalid", {31'b0, if_rvalid_o}, 1);
    check("if_rdata", if_rdata_o, 32'h22221111);
    check("if_no_lsdone", {31'b0, ls_done_o}, 0);
    step();
    check("if_rvalid_pulse", {31'b0, if_rvalid_o}, 0);

    // LW at 0x100, data 0x5678 then 0x1234.
    ls_req_i = 1; ls_we_i = 0; ls_size_i = 2'b10; ls_addr_i = 32'h100; #1;
    check("lw_gnt", {31'b0, ls_gnt_o}, 1);
    check("lw_c0_noreq", {31'b0, mem_req_o}, 0);
    step(); ls_req_i = 0; mem_rdata_i = 16'h5678; #1;
    check("lw_lo_addr", mem_addr_o, 32'h100);
    check("lw_lo_be", {30'b0, mem_be_o}, 2'b11);
    check("lw_lo_we", {31'b0, mem_we_o}, 0);
    step(); mem_rdata_i = 16'h1234; #1;
    check("lw_hi_addr", mem_addr_o, 32'h102);
    check("lw_hi_be", {30'b0, mem_be_o}, 2'b11);
    check("lw_hi_nodone", {31'b0, ls_done_o}, 0);
    step();
    check("lw_done", {31'b0, ls_done_o}, 1);
    check("lw_rdata", ls_rdata_o, 32'h12345678);
    step();
    check("lw_done_pulse", {31'b0, ls_done_o}, 0);

    // SB at 0x203 with 0xAB.
    ls_req_i = 1; ls_we_i = 1; ls_size_i = 2'b00; ls_addr_i = 32'h203; ls_wdata_i = 32'h000000AB; #1;
    check("sb_gnt", {31'b0, ls_gnt_o}, 1);
    step(); ls_req_i = 0; ls_wdata_i = 32'hFFFFFFFF; #1;
    check("sb_addr", mem_addr_o, 32'h202);
    check("sb_be", {30'b0, mem_be_o}, 2'b10);
    check("sb_wdata", {16'b0, mem_wdata_o}, 32'hABAB);
    check("sb_we", {31'b0, mem_we_o}, 1);
    step();
    check("sb_done", {31'b0, ls_done_o}, 1);
    check("sb_rdata_hold", ls_rdata_o, 32'h12345678);
    step();

    // Second tie, immediately after LSU-owned traffic.
    ls_req_i = 1; ls_we_i = 0; ls_size_i = 2'b00; ls_addr_i = 32'h5;
    if_req_i = 1; if_addr_i = 32'h80; #1;
`ifdef MEM_ARB_RR_EN
    check("tie2_if_gnt", {31'b0, if_gnt_o}, 1);
    check("tie2_ls_gnt", {31'b0, ls_gnt_o}, 0);
`else
    check("tie2_if_gnt", {31'b0, if_gnt_o}, 0);
    check("tie2_ls_gnt", {31'b0, ls_gnt_o}, 1);
`endif
    step(); ls_req_i = 0; if_req_i = 0;
    step(); step(); step(); #1;
    check("tie2_idle", {31'b0, mem_req_o}, 0);

    // Misaligned LW at 0x102.
    ls_req_i = 1; ls_we_i = 0; ls_size_i = 2'b10; ls_addr_i = 32'h102; #1;
    check("mis_gnt", {31'b0, ls_gnt_o}, 1);
    check("mis_flag", {31'b0, ls_misalign_o}, 1);
    check("mis_noreq", {31'b0, mem_req_o}, 0);
    step(); ls_req_i = 0; #1;
    check("mis_noreq2", {31'b0, mem_req_o}, 0);
    check("mis_pulse", {31'b0, ls_misalign_o}, 0);

    // Fetch at 0x40 with three wait cycles on BEAT_HI.
    if_req_i = 1; if_addr_i = 32'h40; #1;
    check("st_gnt", {31'b0, if_gnt_o}, 1);
    step(); if_req_i = 0; mem_rdata_i = 16'hAAAA; #1;
    step(); mem_ready_i = 0; mem_rdata_i = 16'hXXXX; #1;
    for (int i = 0; i < 3; i++) begin
      check("st_hold_addr", mem_addr_o, 32'h42);
      check("st_hold_req", {31'b0, mem_req_o}, 1);
      check("st_no_rvalid", {31'b0, if_rvalid_o}, 0);
      step();
    end
    mem_ready_i = 1; mem_rdata_i = 16'hBBBB; #1;
    check("st_last_addr", mem_addr_o, 32'h42);
    step();
    check("st_rvalid", {31'b0, if_rvalid_o}, 1);
    check("st_rdata", if_rdata_o, 32'hBBBBAAAA);
    step();
    check("st_rvalid_once", {31'b0, if_rvalid_o}, 0);

    // Reset during BEAT_HI of an LSU word load.
    ls_req_i = 1; ls_we_i = 0; ls_size_i = 2'b10; ls_addr_i = 32'h300; #1;
    step(); ls_req_i = 0; #1;
    step(); mem_ready_i = 0; #1;
    check("rr_in_hi", mem_addr_o, 32'h302);
    first_cycle = 1'b0; #1;
    check("rr_req_drop", {31'b0, mem_req_o}, 0);
    check("rr_no_done", {31'b0, ls_done_o}, 0);
    step();
    check("rr_no_done2", {31'b0, ls_done_o | ls_gnt_o}, 0);
    check("rr_cleared", ls_rdata_o, 0);
    first_cycle = 1'b1; mem_ready_i = 1; #1;
    check("rr_idle_noreq", {31'b0, mem_req_o}, 0);
    step();
    check("rr_post_no_done", {31'b0, ls_done_o}, 0);

    // Fresh LB at 0x301 after release.
    ls_req_i = 1; ls_size_i = 2'b00; ls_addr_i = 32'h301; #1;
    check("lb_gnt", {31'b0, ls_gnt_o}, 1);
    step(); ls_req_i = 0; mem_rdata_i = 16'hCD12; #1;
    check("lb_addr", mem_addr_o, 32'h300);
    check("lb_be", {30'b0, mem_be_o}, 2'b10);
    step();
    check("lb_done", {31'b0, ls_done_o}, 1);
    check("lb_rdata", ls_rdata_o, 32'h000000CD);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
